// File: rtl/demux_tdm4_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
// Contents:
//   state_t   - frame-lock state (HUNT = no lock, RUN = capturing)
//   NUM_SLOTS - channel slots per frame
//   slot_t    - slot index type (2 bits)
package demux_tdm4_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

endpackage : demux_tdm4_pkg

// File: rtl/demux_tdm4_slot_cnt.sv
// Bit / slot position counter for the TDM demultiplexer.
// The counter tracks the position of the NEXT bit to be sampled.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   en       - advance by one bit position
//   restart  - the current bit is slot 0 bit 0; jump to the position after it
//   clear    - return to slot 0 bit 0
//   bit_idx  - bit position within the current slot
//   slot_idx - current slot
//   last_bit - bit_idx is the final bit of a slot
module tdm_slot_cnt
    import demux_tdm4_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic          clear,
    output logic [BW-1:0] bit_idx,
    output slot_t         slot_idx,
    output logic          last_bit
);

    assign last_bit = (bit_idx == BW'(WIDTH - 1));

    // Position register: clear beats restart, restart beats a plain advance.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_idx  <= '0;
            slot_idx <= 2'd0;
        end else if (restart) begin
            // With one-bit slots, bit 0 of slot 0 is also its last bit.
            if (WIDTH == 1) begin
                bit_idx  <= '0;
                slot_idx <= 2'd1;
            end else begin
                bit_idx  <= BW'(1);
                slot_idx <= 2'd0;
            end
        end else if (en) begin
            if (last_bit) begin
                bit_idx  <= '0;
                slot_idx <= slot_idx + 2'd1;  // wraps 3 -> 0 at frame end
            end else begin
                bit_idx  <= bit_idx + BW'(1);
                slot_idx <= slot_idx;
            end
        end else begin
            bit_idx  <= bit_idx;
            slot_idx <= slot_idx;
        end
    end

endmodule : tdm_slot_cnt

// File: rtl/demux_tdm4.sv
// Four-slot TDM serial demultiplexer.
// A serial stream carries frames of four WIDTH-bit slots, LSB first, with a
// sync marker on the first bit of slot 0. Bits are assembled into per-slot
// shadow words; when a frame completes, all four words are published at once.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   in                - serial data
//   sync              - frame start marker (qualified by en)
//   en                - bit sample enable; all state holds when low
//   out0..out3        - last complete frame, slots 0..3
//   sel1, sel0        - slot index of the next bit to be sampled
//   frame_valid       - one-cycle pulse when out0..out3 update
//   sync_err          - one-cycle pulse on a framing error
module demux_tdm4
    import demux_tdm4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             sync,
    input  logic             en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             sel1,
    output logic             sel0,
    output logic             frame_valid,
    output logic             sync_err
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] shadow [NUM_SLOTS];
    logic [BW-1:0]    bit_idx;
    slot_t            slot_idx;
    logic             last_bit;
    logic             cnt_adv;
    logic             cnt_restart;
    logic             cnt_clear;
    logic             at_start;
    logic             frame_done;
    logic [WIDTH-1:0] cap_word;

    tdm_slot_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_adv),
        .restart  (cnt_restart),
        .clear    (cnt_clear),
        .bit_idx  (bit_idx),
        .slot_idx (slot_idx),
        .last_bit (last_bit)
    );

    // The counter is cleared throughout HUNT, so it reads slot 0 there too.
    assign sel1 = slot_idx[1];
    assign sel0 = slot_idx[0];

    assign at_start   = (bit_idx == '0) && (slot_idx == 2'd0);
    assign frame_done = cnt_adv && last_bit && (slot_idx == 2'd3);

    // Counter control and the current slot word with the incoming bit merged.
    always_comb begin
        cnt_adv     = 1'b0;
        cnt_restart = 1'b0;
        cnt_clear   = 1'b0;
        cap_word    = shadow[slot_idx];
        cap_word[bit_idx] = in;
        if (en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        cnt_restart = 1'b1;
                    end else begin
                        cnt_clear = 1'b0;
                    end
                end
                RUN: begin
                    if (at_start && !sync) begin
                        cnt_clear = 1'b1;        // lost lock
                    end else if (!at_start && sync) begin
                        cnt_restart = 1'b1;      // early sync: realign
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                end
            endcase
        end else begin
            cnt_adv = 1'b0;
        end
    end

    // Frame-lock FSM, shadow capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                shadow[i] <= '0;
                            end
                            shadow[0] <= WIDTH'(in);
                            state     <= RUN;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    RUN: begin
                        if (at_start && !sync) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end else if (!at_start && sync) begin
                            // Partial frame dropped; this bit opens a new one.
                            sync_err <= 1'b1;
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                shadow[i] <= '0;
                            end
                            shadow[0] <= WIDTH'(in);
                        end else begin
                            shadow[slot_idx] <= cap_word;
                            if (frame_done) begin
                                // Slot 3 is not yet in its shadow; use the merged word.
                                out0        <= shadow[0];
                                out1        <= shadow[1];
                                out2        <= shadow[2];
                                out3        <= cap_word;
                                frame_valid <= 1'b1;
                            end else begin
                                frame_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end else begin
                state <= state;
            end
        end
    end

endmodule : demux_tdm4

// File: tb/tb_demux_tdm4.sv
// Directed self-checking bench for demux_tdm4 (WIDTH = 4).
// A frame is handled as a 16-bit vector {w3,w2,w1,w0}; bit k of the vector is
// slot k/4, bit k%4, which is exactly the serial transmission order.
module tb_demux_tdm4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic       en = 1'b0;
    logic [3:0] out0, out1, out2, out3;
    logic       sel1, sel0;
    logic       frame_valid, sync_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fv_n   = 0;
    int se_n   = 0;
    int fv_cyc = 0;
    int fv_cyc_prev = 0;

    demux_tdm4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (din),
        .sync        (sync),
        .en          (en),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .sel1        (sel1),
        .sel0        (sel0),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given inputs; sampled 1 ns after the edge.
    task automatic send_bit(input logic b, input logic s, input logic e);
        din  = b;
        sync = s;
        en   = e;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid === 1'b1) begin
            fv_n++;
            fv_cyc_prev = fv_cyc;
            fv_cyc      = cyc;
        end
        if (sync_err === 1'b1) se_n++;
    endtask

    // Send frame bits from..to; optional sync on the first; optional idle gap
    // (en low with in/sync high, which must be ignored) after every bit.
    task automatic send_bits(input logic [15:0] f, input int from, input int to,
                             input logic sync_first, input logic gap);
        for (int k = from; k <= to; k++) begin
            send_bit(f[k], (k == from) && sync_first, 1'b1);
            if (gap) begin
                send_bit(1'b1, 1'b1, 1'b0);
                check("gap_sel", {30'd0, sel1, sel0}, ((k + 1) % 16) / 4);
                check("gap_fv", frame_valid, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_bit(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] exp);
        check(tag, {out3, out2, out1, out0}, exp);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_outs("rst_out", 16'h0000);
        check("rst_sel", {sel1, sel0}, 2'd0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_se", sync_err, 1'b0);

        // Basic frame 1,2,4,8
        fv_n = 0; se_n = 0;
        send_bits(16'h8421, 0, 14, 1'b1, 1'b0);
        check_outs("f1_early", 16'h0000);
        check("f1_mid_fv", fv_n, 0);
        send_bits(16'h8421, 15, 15, 1'b0, 1'b0);
        check("f1_fv", frame_valid, 1'b1);
        check_outs("f1_out", 16'h8421);
        check("f1_sel", {sel1, sel0}, 2'd0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("f1_fv_drop", frame_valid, 1'b0);
        check("f1_fv_n", fv_n, 1);

        // Same frame with en low every other cycle
        do_reset();
        fv_n = 0; se_n = 0;
        send_bits(16'h8421, 0, 15, 1'b1, 1'b1);
        check_outs("gap_out", 16'h8421);
        check("gap_fv_n", fv_n, 1);
        check("gap_se_n", se_n, 0);

        // Back-to-back frames
        fv_n = 0; se_n = 0;
        send_bits(16'hDCBA, 0, 15, 1'b1, 1'b0);
        check_outs("b2b_out1", 16'hDCBA);
        send_bits(16'h8765, 0, 15, 1'b1, 1'b0);
        check_outs("b2b_out2", 16'h8765);
        check("b2b_fv_n", fv_n, 2);
        check("b2b_spacing", fv_cyc - fv_cyc_prev, 16);

        // Next frame without sync: error at first bit, then HUNT
        fv_n = 0; se_n = 0;
        send_bit(1'b1, 1'b0, 1'b1);
        check("nosync_se", sync_err, 1'b1);
        send_bits(16'h4321, 1, 15, 1'b0, 1'b0);
        check("nosync_se_n", se_n, 1);
        check("nosync_fv_n", fv_n, 0);
        check_outs("nosync_out", 16'h8765);
        check("nosync_sel", {sel1, sel0}, 2'd0);

        // Sync reasserted at bit 6 restarts the frame
        fv_n = 0; se_n = 0;
        send_bits(16'h0421, 0, 5, 1'b1, 1'b0);
        check("early_sel_pre", {sel1, sel0}, 2'd1);
        send_bit(1'b1, 1'b1, 1'b1);             // bit 0 of 16'hC369
        check("early_se", sync_err, 1'b1);
        check("early_sel", {sel1, sel0}, 2'd0);
        check_outs("early_hold", 16'h8765);
        send_bits(16'hC369, 1, 14, 1'b0, 1'b0);
        check_outs("early_hold2", 16'h8765);
        send_bits(16'hC369, 15, 15, 1'b0, 1'b0);
        check_outs("early_out", 16'hC369);
        check("early_fv_n", fv_n, 1);
        check("early_se_n", se_n, 1);

        // Reset at bit 10, then HUNT ignores unsynced bits, then a clean frame
        fv_n = 0; se_n = 0;
        send_bits(16'h1234, 0, 9, 1'b1, 1'b0);
        do_reset();
        check_outs("mid_rst_out", 16'h0000);
        check("mid_rst_sel", {sel1, sel0}, 2'd0);
        check("mid_rst_fv_n", fv_n, 0);
        check("mid_rst_se", sync_err, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("hunt_sel", {sel1, sel0}, 2'd0);
        check("hunt_se_n", se_n, 0);
        send_bits(16'hE7B2, 0, 15, 1'b1, 1'b0);
        check_outs("post_rst_out", 16'hE7B2);
        check("post_rst_fv_n", fv_n, 1);
        check("post_rst_se_n", se_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux_tdm4
